lcd_multiline_feed: RTL and testbench

LCD_MULTILINE_FEED -- requirements
Module: lcd_multiline_feed

---
 rtl/lcd_multiline_feed.sv | 125 ++++++++++++
 tb/tb_lcd_multiline_feed.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_multiline_feed.sv
// Sequences LCD refresh commands: clear display, then each text line, then a refresh pause.
// Every step is paced by the driver's ready handshake and guarded by an acknowledge timeout.
module lcd_multiline_feed #(
  parameter int unsigned parm_fast_simulation   = 0,
  parameter int unsigned parm_line_count        = 2,
  parameter int unsigned parm_step_delay_ticks  = 2500,
  parameter int unsigned parm_refresh_ticks     = 495000,
  parameter int unsigned parm_ack_timeout_ticks = 25000
) (
  input  logic                       i_clk_20mhz,
  input  logic                       i_rst_20mhz,
  input  logic                       i_ce_2_5mhz,
  input  logic                       i_lcd_command_ready,
  input  logic                       i_enable,
  input  logic                       i_refresh_now,
  output logic                       o_lcd_wr_clear_display,
  output logic [parm_line_count-1:0] o_lcd_wr_text_line,
  output logic                       o_lcd_feed_is_idle,
  output logic                       o_ack_timeout,
  output logic [15:0]                o_refresh_count
);

  localparam int unsigned FastTicks    = (parm_refresh_ticks / 25 < 1) ? 1 :
                                         parm_refresh_ticks / 25;
  localparam int unsigned RefreshTicks = (parm_fast_simulation != 0) ? FastTicks :
                                         parm_refresh_ticks;
  localparam logic [23:0] StepLast     = 24'(parm_step_delay_ticks - 1);
  localparam logic [23:0] RefreshLast  = 24'(RefreshTicks - 1);
  localparam logic [23:0] AckLast      = 24'(parm_ack_timeout_ticks - 1);
  localparam int unsigned IdxW         = (parm_line_count > 1) ? $clog2(parm_line_count) : 1;
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(parm_line_count - 1);

  typedef enum logic [2:0] {
    StPause, StClearRun, StClearDly, StClearWait,
    StLineRun, StLineDly, StLineWait, StRefreshDly
  } state_e;

  state_e            state_q, state_d;
  logic [23:0]       timer_q;
  logic [IdxW-1:0]   index_q, index_d;
  logic [15:0]       count_q;
  logic              count_inc;
  logic              abort;
  logic              ack_q;
  logic              in_run_wait;

  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state_q <= StPause;
      timer_q <= '0;
      index_q <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      // Abort is only decided on CE cycles, so the flag is a one-clock pulse.
      ack_q <= i_ce_2_5mhz && abort;
      if (i_ce_2_5mhz) begin
        state_q <= state_d;
        index_q <= index_d;
        if (state_d != state_q) begin
          timer_q <= '0;
        end else if (timer_q != '1) begin
          timer_q <= timer_q + 1'b1;
        end
        if (count_inc) begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    count_inc   = 1'b0;
    abort       = 1'b0;
    in_run_wait = (state_q == StClearRun) || (state_q == StClearWait) ||
                  (state_q == StLineRun)  || (state_q == StLineWait);
    unique case (state_q)
      StPause: begin
        if (i_enable && i_lcd_command_ready) begin
          state_d = StClearRun;
          index_d = '0;
        end
      end
      StClearRun:   if (!i_lcd_command_ready) state_d = StClearDly;
      StClearDly:   if (timer_q == StepLast) state_d = StClearWait;
      StClearWait:  if (i_lcd_command_ready) state_d = StLineRun;
      StLineRun:    if (!i_lcd_command_ready) state_d = StLineDly;
      StLineDly:    if (timer_q == StepLast) state_d = StLineWait;
      StLineWait: begin
        if (i_lcd_command_ready) begin
          if (index_q < LastIdx) begin
            index_d = index_q + 1'b1;
            state_d = StLineRun;
          end else begin
            state_d   = StRefreshDly;
            count_inc = 1'b1;
          end
        end
      end
      StRefreshDly: if ((timer_q == RefreshLast) || i_refresh_now) state_d = StPause;
      default:      state_d = StPause;
    endcase
    // Timeout wins over any handshake transition decided on the same tick.
    if (in_run_wait && (timer_q == AckLast)) begin
      state_d   = StPause;
      index_d   = index_q;
      count_inc = 1'b0;
      abort     = 1'b1;
    end
  end

  always_comb begin
    o_lcd_wr_clear_display = (state_q == StClearRun);
    o_lcd_wr_text_line     = '0;
    for (int k = 0; k < int'(parm_line_count); k++) begin
      o_lcd_wr_text_line[k] = (state_q == StLineRun) && (int'(index_q) == k);
    end
    o_lcd_feed_is_idle = (state_q == StPause) || (state_q == StRefreshDly);
    o_ack_timeout      = ack_q;
    o_refresh_count    = count_q;
  end

endmodule

// File: tb/tb_lcd_multiline_feed.sv
// Directed bench for lcd_multiline_feed: two-line and four-line instances with a
// ready-handshake model (ready drops 2 ticks after a strobe, returns 100 ticks later).
module tb_lcd_multiline_feed;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b1;
  logic refresh_now = 1'b0;
  logic enable2 = 1'b0;
  logic enable4 = 1'b0;
  logic ready_drv = 1'b1;
  logic [1:0] model_en = 2'b00;
  logic [1:0] model_ready = 2'b11;
  int hs_cnt [2] = '{0, 0};
  logic ready2, ready4;

  logic clear2, idle2, ack2;
  logic [1:0] line2;
  logic [15:0] count2;
  logic clear4, idle4, ack4;
  logic [3:0] line4;
  logic [15:0] count4;

  logic [4:0] vec2, vec4;
  logic [1:0] strobe_any;

  int checks = 0;
  int failures = 0;

  logic [4:0] ev2[$];
  logic [4:0] ev4[$];
  int gap2[$];
  int gap_cnt = 0;
  logic [4:0] prev2 = '0;
  logic [4:0] prev4 = '0;
  int bad2 = 0;
  int bad4 = 0;
  int ack2_n = 0;

  always #25 clk = ~clk;

  assign ready2 = model_en[0] ? model_ready[0] : ready_drv;
  assign ready4 = model_en[1] ? model_ready[1] : ready_drv;
  assign vec2 = {clear2, 2'b00, line2};
  assign vec4 = {clear4, line4};
  assign strobe_any = {|vec4, |vec2};

  lcd_multiline_feed #(
    .parm_fast_simulation(1),
    .parm_line_count(2)
  ) u_dut2 (
    .i_clk_20mhz(clk),
    .i_rst_20mhz(rst),
    .i_ce_2_5mhz(ce),
    .i_lcd_command_ready(ready2),
    .i_enable(enable2),
    .i_refresh_now(refresh_now),
    .o_lcd_wr_clear_display(clear2),
    .o_lcd_wr_text_line(line2),
    .o_lcd_feed_is_idle(idle2),
    .o_ack_timeout(ack2),
    .o_refresh_count(count2)
  );

  lcd_multiline_feed #(
    .parm_fast_simulation(1),
    .parm_line_count(4)
  ) u_dut4 (
    .i_clk_20mhz(clk),
    .i_rst_20mhz(rst),
    .i_ce_2_5mhz(ce),
    .i_lcd_command_ready(ready4),
    .i_enable(enable4),
    .i_refresh_now(1'b0),
    .o_lcd_wr_clear_display(clear4),
    .o_lcd_wr_text_line(line4),
    .o_lcd_feed_is_idle(idle4),
    .o_ack_timeout(ack4),
    .o_refresh_count(count4)
  );

  // Handshake model of the LCD driver.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (!model_en[m]) begin
        hs_cnt[m] <= 0;
        model_ready[m] <= 1'b1;
      end else if (hs_cnt[m] == 0) begin
        if (strobe_any[m]) hs_cnt[m] <= 1;
      end else begin
        hs_cnt[m] <= hs_cnt[m] + 1;
        if (hs_cnt[m] == 2) model_ready[m] <= 1'b0;
        if (hs_cnt[m] == 102) begin
          model_ready[m] <= 1'b1;
          hs_cnt[m] <= 0;
        end
      end
    end
  end

  // Strobe event recorder; gap counts busy non-strobe ticks before each line strobe.
  always @(negedge clk) begin
    if (vec2 != 5'd0 && vec2 != prev2) begin
      ev2.push_back(vec2);
      if (vec2[3:0] != 4'd0) gap2.push_back(gap_cnt);
    end
    if (vec4 != 5'd0 && vec4 != prev4) ev4.push_back(vec4);
    gap_cnt = (vec2 == 5'd0 && !idle2) ? gap_cnt + 1 : 0;
    prev2 = vec2;
    prev4 = vec4;
    if ($countones(vec2) > 1) bad2++;
    if ($countones(vec4) > 1) bad4++;
    if (ack2) ack2_n++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++; if (idle2 !== 1'b1) begin failures++; $display("FAIL reset_idle2 got=%b exp=1", idle2); end
    checks++; if (vec2 !== 5'd0) begin failures++; $display("FAIL reset_strobes2 got=%b exp=00000", vec2); end
    checks++; if (count2 !== 16'd0) begin failures++; $display("FAIL reset_count2 got=%0d exp=0", count2); end
    checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL reset_ack2 got=%b exp=0", ack2); end
    checks++; if (idle4 !== 1'b1 || vec4 !== 5'd0) begin
      failures++; $display("FAIL reset_dut4 got idle=%b strobes=%b exp idle=1 strobes=00000", idle4, vec4);
    end
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (idle2 !== 1'b1 || vec2 !== 5'd0) begin
      failures++; $display("FAIL post_reset_hold got idle=%b strobes=%b exp idle=1 strobes=00000", idle2, vec2);
    end
  endtask

  task automatic test_ce_gating();
    ce = 1'b0;
    enable2 = 1'b1;
    model_en[0] = 1'b1;
    ev2.delete();
    gap2.delete();
    repeat (5) tick();
    checks++; if (vec2 !== 5'd0 || idle2 !== 1'b1) begin
      failures++; $display("FAIL ce_low_hold got strobes=%b idle=%b exp strobes=00000 idle=1", vec2, idle2);
    end
    ce = 1'b1;
    tick();
    checks++; if (vec2 !== 5'b10000) begin failures++; $display("FAIL ce_start_clear got=%b exp=10000", vec2); end
  endtask

  task automatic test_sequence();
    int n;
    logic [4:0] exp_seq [3];
    exp_seq = '{5'b10000, 5'b00001, 5'b00010};
    n = 0;
    while (!idle2 && n < 20000) begin tick(); n++; end
    checks++; if (idle2 !== 1'b1) begin failures++; $display("FAIL seq_complete got idle=%b exp=1", idle2); end
    checks++; if (ev2.size() != 3) begin failures++; $display("FAIL seq_event_count got=%0d exp=3", ev2.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= ev2.size() || ev2[i] !== exp_seq[i]) begin
        failures++; $display("FAIL seq_order[%0d] got=%b exp=%b", i, (i < ev2.size()) ? ev2[i] : 5'bx, exp_seq[i]);
      end
    end
    // Each line strobe follows a 2500-tick DLY plus one WAIT tick with ready already high.
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= gap2.size() || gap2[i] != 2501) begin
        failures++; $display("FAIL seq_dly_len[%0d] got=%0d exp=2501", i, (i < gap2.size()) ? gap2[i] : -1);
      end
    end
    checks++; if (count2 !== 16'd1) begin failures++; $display("FAIL seq_refresh_count got=%0d exp=1", count2); end
    checks++; if (bad2 != 0 || bad4 != 0) begin
      failures++; $display("FAIL onehot got=%0d/%0d exp=0/0", bad2, bad4);
    end
    checks++; if (ack2_n != 0) begin failures++; $display("FAIL seq_no_timeout got=%0d exp=0", ack2_n); end
  endtask

  task automatic test_refresh_now();
    ev2.delete();
    repeat (10) tick();
    refresh_now = 1'b1;
    tick();
    refresh_now = 1'b0;
    checks++; if (idle2 !== 1'b1 || vec2 !== 5'd0) begin
      failures++; $display("FAIL refresh_now_pause got idle=%b strobes=%b exp idle=1 strobes=00000", idle2, vec2);
    end
    tick();
    checks++; if (vec2 !== 5'b10000) begin failures++; $display("FAIL refresh_now_clear got=%b exp=10000", vec2); end
  endtask

  task automatic test_enable_drop();
    int n;
    logic [4:0] exp_seq [3];
    exp_seq = '{5'b10000, 5'b00001, 5'b00010};
    n = 0;
    while (vec2[3:0] == 4'd0 && n < 10000) begin tick(); n++; end
    checks++; if (vec2[3:0] !== 4'b0001) begin failures++; $display("FAIL drop_line_run got=%b exp=0001", vec2[3:0]); end
    enable2 = 1'b0;
    n = 0;
    while (!idle2 && n < 10000) begin tick(); n++; end
    checks++; if (count2 !== 16'd2) begin failures++; $display("FAIL drop_count got=%0d exp=2", count2); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= ev2.size() || ev2[i] !== exp_seq[i]) begin
        failures++; $display("FAIL drop_order[%0d] got=%b exp=%b", i, (i < ev2.size()) ? ev2[i] : 5'bx, exp_seq[i]);
      end
    end
    refresh_now = 1'b1;
    tick();
    refresh_now = 1'b0;
    repeat (300) tick();
    checks++; if (ev2.size() != 3 || idle2 !== 1'b1) begin
      failures++; $display("FAIL drop_parked got events=%0d idle=%b exp events=3 idle=1", ev2.size(), idle2);
    end
  endtask

  task automatic test_timeout();
    int n;
    model_en[0] = 1'b0;
    ready_drv = 1'b1;
    enable2 = 1'b1;
    n = 0;
    while (!clear2 && n < 100) begin tick(); n++; end
    checks++; if (clear2 !== 1'b1) begin failures++; $display("FAIL to_clear_start got=%b exp=1", clear2); end
    enable2 = 1'b0;
    n = 0;
    while (!ack2 && n < 30000) begin tick(); n++; end
    checks++; if (n != 25000) begin failures++; $display("FAIL to_latency got=%0d exp=25000", n); end
    checks++; if (idle2 !== 1'b1 || vec2 !== 5'd0) begin
      failures++; $display("FAIL to_pause got idle=%b strobes=%b exp idle=1 strobes=00000", idle2, vec2);
    end
    tick();
    checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL to_pulse_width got=%b exp=0", ack2); end
    checks++; if (count2 !== 16'd2) begin failures++; $display("FAIL to_count got=%0d exp=2", count2); end
    checks++; if (ack2_n != 1) begin failures++; $display("FAIL to_pulse_count got=%0d exp=1", ack2_n); end
  endtask

  task automatic test_lines4();
    int n;
    logic [4:0] exp_seq [5];
    exp_seq = '{5'b10000, 5'b00001, 5'b00010, 5'b00100, 5'b01000};
    ev4.delete();
    model_en[1] = 1'b1;
    enable4 = 1'b1;
    n = 0;
    while (vec4 == 5'd0 && n < 100) begin tick(); n++; end
    enable4 = 1'b0;
    n = 0;
    while (!idle4 && n < 20000) begin tick(); n++; end
    checks++; if (ev4.size() != 5) begin failures++; $display("FAIL l4_event_count got=%0d exp=5", ev4.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= ev4.size() || ev4[i] !== exp_seq[i]) begin
        failures++; $display("FAIL l4_order[%0d] got=%b exp=%b", i, (i < ev4.size()) ? ev4[i] : 5'bx, exp_seq[i]);
      end
    end
    checks++; if (count4 !== 16'd1) begin failures++; $display("FAIL l4_count got=%0d exp=1", count4); end
  endtask

  task automatic test_reset_in_dly();
    int n;
    model_en[0] = 1'b1;
    enable2 = 1'b1;
    n = 0;
    while (vec2[3:0] == 4'd0 && n < 10000) begin tick(); n++; end
    enable2 = 1'b0;
    n = 0;
    while (vec2 != 5'd0 && n < 100) begin tick(); n++; end
    repeat (50) tick();
    checks++; if (idle2 !== 1'b0 || vec2 !== 5'd0) begin
      failures++; $display("FAIL rd_in_dly got idle=%b strobes=%b exp idle=0 strobes=00000", idle2, vec2);
    end
    rst = 1'b1;
    tick();
    checks++; if (idle2 !== 1'b1) begin failures++; $display("FAIL rd_idle got=%b exp=1", idle2); end
    checks++; if (vec2 !== 5'd0) begin failures++; $display("FAIL rd_strobes got=%b exp=00000", vec2); end
    checks++; if (count2 !== 16'd0 || count4 !== 16'd0) begin
      failures++; $display("FAIL rd_counts got=%0d/%0d exp=0/0", count2, count4);
    end
    checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL rd_ack got=%b exp=0", ack2); end
    rst = 1'b0;
    repeat (5) tick();
    checks++; if (idle2 !== 1'b1 || vec2 !== 5'd0) begin
      failures++; $display("FAIL rd_after got idle=%b strobes=%b exp idle=1 strobes=00000", idle2, vec2);
    end
  endtask

  initial begin
    test_reset();
    test_ce_gating();
    test_sequence();
    test_refresh_now();
    test_enable_drop();
    test_timeout();
    test_lines4();
    test_reset_in_dly();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
